// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a start/busy/done handshake.
// Single-cycle ops: add, xor, sub, popcount, illegal-opcode reporting.
// Multi-cycle ops: shift-add multiply (WIDTH steps) and, when the macro
// ALU_SEQ_DIV_EN is defined, an unsigned restoring divider (WIDTH steps).
// Without ALU_SEQ_DIV_EN, opcode 100 reports illegal and dz stays 0.
// Every output is a register; no input reaches an output combinationally.
`timescale 1ns/1ps

module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             ovf,
    output logic             dz,
    output logic             err
);

    // Step counter must be able to hold WIDTH-1.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     opa_r;   // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0]     opb_r;   // multiplier (shifted right), or divisor
    logic [2*WIDTH-1:0]   acc_r;   // product accumulator; low half is the remainder in DIV

    // Single-cycle result path
    logic [WIDTH-1:0]     sc_result_s;
    logic                 sc_ovf_s;
    logic                 sc_dz_s;
    logic                 sc_err_s;
    logic                 sc_multi_s;

    // Multiply step
    logic [WIDTH-1:0]     mul_addend_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_acc_s;

    // Number of ones in v, zero-extended to WIDTH bits.
    function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{(WIDTH-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Decode the opcode and compute every single-cycle outcome from live inputs.
    always_comb begin
        sc_result_s = '0;
        sc_ovf_s    = 1'b0;
        sc_dz_s     = 1'b0;
        sc_err_s    = 1'b0;
        sc_multi_s  = 1'b0;
        case (sel)
            3'b000: {sc_ovf_s, sc_result_s} = {1'b0, a} + {1'b0, b};
            3'b001: sc_result_s = a ^ b;
            3'b010: begin
                sc_result_s = a - b;
                sc_ovf_s    = (a < b);
            end
            3'b011: sc_multi_s = 1'b1;
            3'b100: begin
`ifdef ALU_SEQ_DIV_EN
                if (b == '0) begin
                    sc_result_s = '1;
                    sc_dz_s     = 1'b1;
                end else begin
                    sc_multi_s  = 1'b1;
                end
`else
                sc_err_s = 1'b1;
`endif
            end
            3'b101: sc_result_s = popcount(b);
            default: sc_err_s = 1'b1;
        endcase
    end

    // One shift-add step: add the multiplicand into the high half, then shift right.
    always_comb begin
        if (opb_r[0]) begin
            mul_addend_s = opa_r;
        end else begin
            mul_addend_s = '0;
        end
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend_s};
        mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_qbit_s;
    logic [WIDTH-1:0]     div_rem_s;
    logic [WIDTH-1:0]     div_quo_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        div_shift_s = {acc_r[WIDTH-1:0], opa_r[WIDTH-1]};
        if (div_shift_s >= {1'b0, opb_r}) begin
            div_qbit_s = 1'b1;
            div_diff_s = div_shift_s - {1'b0, opb_r};
        end else begin
            div_qbit_s = 1'b0;
            div_diff_s = div_shift_s;
        end
        div_rem_s = div_diff_s[WIDTH-1:0];
        div_quo_s = {opa_r[WIDTH-2:0], div_qbit_s};
    end
`endif

    // Control FSM, operand latches, iterative datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            opa_r   <= '0;
            opb_r   <= '0;
            acc_r   <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (sc_multi_s) begin
                            opa_r   <= a;
                            opb_r   <= b;
                            acc_r   <= '0;
                            cnt_r   <= '0;
                            busy    <= 1'b1;
                            state_r <= (sel == 3'b011) ? MUL : DIV;
                        end else begin
                            result <= sc_result_s;
                            ovf    <= sc_ovf_s;
                            dz     <= sc_dz_s;
                            err    <= sc_err_s;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_r <= mul_acc_s;
                    opb_r <= opb_r >> 1;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        result  <= mul_acc_s[WIDTH-1:0];
                        ovf     <= |mul_acc_s[2*WIDTH-1:WIDTH];
                        dz      <= 1'b0;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end
                end
                DIV: begin
`ifdef ALU_SEQ_DIV_EN
                    acc_r <= {{WIDTH{1'b0}}, div_rem_s};
                    opa_r <= div_quo_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        result  <= div_quo_s;
                        ovf     <= 1'b0;
                        dz      <= 1'b0;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end
`else
                    busy    <= 1'b0;
                    state_r <= IDLE;
`endif
                end
                default: begin
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vector table,
// hand-written handshake/abort sequences and randomized ops against a model.
`timescale 1ns/1ps

module tb_alu_seq;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        ovf;
    logic        dz;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        dz;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
    } vec_t;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
        .result(result), .done(done), .busy(busy), .ovf(ovf), .dz(dz), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operation's definition.
    function automatic exp_t model(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int unsigned ux, uy, t;
        ux = x; uy = y;
        e.res = 16'h0000; e.ovf = 1'b0; e.dz = 1'b0; e.err = 1'b0; e.lat = 1;
        case (s)
            3'd0: begin t = ux + uy; e.res = t[15:0]; e.ovf = (t > 32'd65535); end
            3'd1: e.res = x ^ y;
            3'd2: begin t = ux - uy; e.res = t[15:0]; e.ovf = (ux < uy); end
            3'd3: begin t = ux * uy; e.res = t[15:0]; e.ovf = (t > 32'd65535); e.lat = 17; end
            3'd4: begin
                if (!DIV_EN) e.err = 1'b1;
                else if (uy == 0) begin e.res = 16'hFFFF; e.dz = 1'b1; end
                else begin t = ux / uy; e.res = t[15:0]; e.lat = 17; end
            end
            3'd5: e.res = 16'($countones(y));
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input string n, input logic [2:0] s, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] r, input logic o,
                                input logic z, input logic er, input int l);
        vec_t v;
        v.name = n; v.sel = s; v.a = x; v.b = y;
        v.e.res = r; v.e.ovf = o; v.e.dz = z; v.e.err = er; v.e.lat = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op from a negedge and follow it until done; ends on the done negedge.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [15:0] x,
                          input logic [15:0] y, input exp_t e);
        int k;
        int nbusy;
        start = 1'b1; sel = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        k = 1; nbusy = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(e.lat));
        chk({tag, " result"}, {16'h0, result}, {16'h0, e.res});
        chk({tag, " ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
        chk({tag, " dz"}, {31'h0, dz}, {31'h0, e.dz});
        chk({tag, " err"}, {31'h0, err}, {31'h0, e.err});
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(e.lat - 1));
        chk({tag, " busy_at_done"}, {31'h0, busy}, 32'h0);
    endtask

    vec_t vecs[16];

    initial begin
        int k;
        int ndone;
        int lat_seen;
        logic [15:0] res_seen;
        logic ovf_seen;
        exp_t e;
        logic [2:0] rs;
        logic [15:0] ra, rb;

        vecs[0]  = mk("add_wrap",  3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        vecs[1]  = mk("sub_borrow",3'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1);
        vecs[2]  = mk("xor",       3'd1, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1);
        vecs[3]  = mk("popcnt",    3'd5, 16'h1234, 16'hF00F, 16'h0008, 1'b0, 1'b0, 1'b0, 1);
        vecs[4]  = mk("mul_ovf",   3'd3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 17);
        vecs[5]  = mk("mul_full",  3'd3, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17);
        vecs[6]  = mk("div_big",   3'd4, 16'hFFFF, 16'h0010, DIV_EN ? 16'h0FFF : 16'h0000,
                      1'b0, 1'b0, !DIV_EN, DIV_EN ? 17 : 1);
        vecs[7]  = mk("div_zero",  3'd4, 16'h0007, 16'h0000, DIV_EN ? 16'hFFFF : 16'h0000,
                      1'b0, DIV_EN, !DIV_EN, 1);
        vecs[8]  = mk("div_100_5", 3'd4, 16'd100, 16'd5, DIV_EN ? 16'd20 : 16'd0,
                      1'b0, 1'b0, !DIV_EN, DIV_EN ? 17 : 1);
        vecs[9]  = mk("ill_110",   3'd6, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        vecs[10] = mk("ill_111",   3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        vecs[11] = mk("add_zero",  3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
        vecs[12] = mk("sub_equal", 3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
        vecs[13] = mk("popcnt_all",3'd5, 16'h0000, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 1'b0, 1);
        vecs[14] = mk("mul_max",   3'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 17);
        vecs[15] = mk("mul_zero",  3'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 17);

        rst_n = 1'b0; start = 1'b0; sel = 3'd0; a = 16'h0; b = 16'h0;

        // Reset state
        @(negedge clk);
        chk("reset_result", {16'h0, result}, 32'h0);
        chk("reset_flags", {26'h0, done, busy, ovf, dz, err, 1'b0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort: mul 3*5, reset in cycle n+4
        start = 1'b1; sel = 3'd3; a = 16'd3; b = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_in_reset", {31'h0, busy}, 32'h0);
        chk("abort_done_in_reset", {31'h0, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_busy_after", {31'h0, busy}, 32'h0);

        // Directed vector table, issued back to back
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].e);
        end

        // Start and operand changes while a mul runs
        e = model(3'd3, 16'h1234, 16'h0056);
        start = 1'b1; sel = 3'd3; a = 16'h1234; b = 16'h0056;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat_seen = 0; res_seen = 16'h0; ovf_seen = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            if (done === 1'b1) begin
                ndone++;
                if (lat_seen == 0) begin
                    lat_seen = j; res_seen = result; ovf_seen = ovf;
                end
            end
            if (j == 3) begin
                start = 1'b1; sel = 3'd0; a = 16'd1; b = 16'd1;
            end else if (j == 4) begin
                start = 1'b0; sel = 3'd2; a = 16'hFFFF; b = 16'hFFFF;
            end else if (j == 10) begin
                start = 1'b1; sel = 3'd3;
            end else if (j == 11) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy_ignore_ndone", 32'(ndone), 32'h1);
        chk("busy_ignore_latency", 32'(lat_seen), 32'(e.lat));
        chk("busy_ignore_result", {16'h0, res_seen}, {16'h0, e.res});
        chk("busy_ignore_ovf", {31'h0, ovf_seen}, {31'h0, e.ovf});

        // Five consecutive add starts
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; sel = 3'd0; a = 16'(i * 1000 + 65000); b = 16'(i + 7);
            e = model(3'd0, a, b);
            @(negedge clk);
            chk($sformatf("b2b_add%0d done", i), {31'h0, done}, 32'h1);
            chk($sformatf("b2b_add%0d result", i), {16'h0, result}, {16'h0, e.res});
            chk($sformatf("b2b_add%0d ovf", i), {31'h0, ovf}, {31'h0, e.ovf});
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_done_drops", {31'h0, done}, 32'h0);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            k = int'($urandom_range(0, 3));
            if (k == 0) rb = 16'h0000;
            else if (k == 1) rb = 16'($urandom_range(1, 40));
            e = model(rs, ra, rb);
            run_op($sformatf("rnd%0d sel%0d", i, rs), rs, ra, rb, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
